sort_frame_loader: RTL and testbench

//  Upstream stage of the sorter. Collects a frame of elements arriving one
//  per cycle on a valid/ready stream into a parallel buffer of

---
 rtl/sort_frame_loader.sv | 183 ++++++++++++++++++
 tb/tb_sort_frame_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_frame_loader.sv
// -----------------------------------------------------------------------------
// sort_frame_loader
//
// Upstream stage of the sorter. It collects one frame of elements from a
// valid/ready stream into a parallel buffer of INPUT_ARR_SIZE entries. Unused
// slots read PAD_VALUE. The complete array is then offered to the sorter with a
// valid/ready handoff. The buffer is single-entry, so the next frame is
// accepted only after the sorter has taken the current array.
//
// Parameters
//   INPUT_ARR_SIZE  entries per frame (N, >= 2)
//   ELEMENT_SIZE    bits per element
//   PAD_VALUE       fill value for unused slots
//
// Ports
//   clk           in   clock, all logic on posedge
//   rst_n         in   synchronous active-low reset
//   in_data       in   stream element
//   in_valid      in   in_data valid
//   in_last       in   final element of the frame (sampled on accept only)
//   in_ready      out  loader accepts an element this cycle
//   arr_data      out  parallel array [0:N-1] to the sorter
//   arr_count     out  number of real (non-pad) entries in arr_data
//   arr_valid     out  arr_data/arr_count complete and stable
//   arr_ready     in   sorter takes the array
//   overflow_err  out  sticky flag: a frame longer than N was received
//
// Build option
//   LOADER_OVERFLOW_ERR_EN  When defined, overflow_err is set on the first
//                           element dropped by an over-long frame, and it
//                           stays set until reset. When undefined,
//                           overflow_err is tied low. Overflow elements are
//                           dropped in both builds.
// -----------------------------------------------------------------------------
module sort_frame_loader #(
  parameter int unsigned                INPUT_ARR_SIZE = 100,
  parameter int unsigned                ELEMENT_SIZE   = 32,
  parameter logic [ELEMENT_SIZE-1:0]    PAD_VALUE      = {ELEMENT_SIZE{1'b1}},
  localparam int unsigned               COUNT_W        = $clog2(INPUT_ARR_SIZE + 1),
  localparam int unsigned               IDX_W          = $clog2(INPUT_ARR_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ELEMENT_SIZE-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [ELEMENT_SIZE-1:0] arr_data [0:INPUT_ARR_SIZE-1],
  output logic [COUNT_W-1:0]      arr_count,
  output logic                    arr_valid,
  input  logic                    arr_ready,
  output logic                    overflow_err
);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,  // writing elements into the buffer
    ST_DISCARD = 2'd1,  // buffer full, dropping elements until in_last
    ST_HOLD    = 2'd2   // array offered to the sorter
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic [COUNT_W-1:0]      count_q, count_d;
  logic [ELEMENT_SIZE-1:0] buf_q [0:INPUT_ARR_SIZE-1];

  logic accept;     // element handshake on this edge
  logic wr_en;      // write in_data into buf_q[wr_idx_q]
  logic clear_all;  // rewrite every entry to PAD_VALUE (handoff)
  logic last_slot;  // current write lands in slot N-1

  assign accept    = in_valid && in_ready;
  assign last_slot = (wr_idx_q == IDX_W'(INPUT_ARR_SIZE - 1));

  // ---------------------------------------------------------------------------
  // Control: next state, counters and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    count_d   = count_q;
    wr_en     = 1'b0;
    clear_all = 1'b0;
    in_ready  = 1'b0;
    arr_valid = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en    = 1'b1;
          count_d  = count_q + COUNT_W'(1);
          wr_idx_d = wr_idx_q + IDX_W'(1);
          // in_last has priority, so a frame of exactly N elements ends in HOLD.
          if (in_last) begin
            state_d = ST_HOLD;
          end else if (last_slot) begin
            state_d = ST_DISCARD;
          end
        end
      end

      ST_DISCARD: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        arr_valid = 1'b1;
        if (arr_ready) begin
          state_d   = ST_FILL;
          wr_idx_d  = '0;
          count_d   = '0;
          clear_all = 1'b1;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_FILL;
      wr_idx_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Element buffer
  // ---------------------------------------------------------------------------
  // NOTE: this storage is reset on purpose. Slots beyond the end of a short
  // frame must read PAD_VALUE, and both reset and handoff provide that value.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_all) begin
      for (int i = 0; i < int'(INPUT_ARR_SIZE); i++) begin
        buf_q[i] <= PAD_VALUE;
      end
    end else if (wr_en) begin
      buf_q[wr_idx_q] <= in_data;
    end
  end

  assign arr_data  = buf_q;
  assign arr_count = count_q;

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------
`ifdef LOADER_OVERFLOW_ERR_EN
  logic ovf_q, ovf_d;

  // The flag sets on the first dropped element and stays set until reset.
  always_comb begin
    ovf_d = ovf_q | (accept && (state_q == ST_DISCARD));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_err = ovf_q;
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_sort_frame_loader
//
// Directed bench for sort_frame_loader with N=8 and 32-bit elements. A small
// reference model builds each expected frame as elements are sent and pushes
// it to a scoreboard. The expected frame is popped and compared when the DUT
// raises arr_valid. Inputs change on the falling edge, and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sort_frame_loader;

  localparam int          N   = 8;
  localparam int          W   = 32;
  localparam int          CW  = $clog2(N + 1);
  localparam logic [W-1:0] PAD = 32'hFFFF_FFFF;

  typedef logic [N-1:0][W-1:0] frame_t;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [W-1:0]  arr_data [0:N-1];
  logic [CW-1:0] arr_count;
  logic          arr_valid;
  logic          arr_ready;
  logic          overflow_err;

  sort_frame_loader #(
    .INPUT_ARR_SIZE (N),
    .ELEMENT_SIZE   (W),
    .PAD_VALUE      (PAD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .arr_data     (arr_data),
    .arr_count    (arr_count),
    .arr_valid    (arr_valid),
    .arr_ready    (arr_ready),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     vectors = 0;
  int     errors  = 0;
  frame_t q_frame[$];
  int     q_cnt[$];
  frame_t m_frame;
  int     m_cnt;
  logic   exp_ovf;

  function automatic frame_t pad_frame();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = PAD;
    return f;
  endfunction

  function automatic frame_t snap();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = arr_data[i];
    return f;
  endfunction

  task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_frame = pad_frame();
    m_cnt   = 0;
  endtask

  // Sends one element. The caller guarantees that the loader is in FILL or
  // DISCARD, so in_ready must be high and arr_valid must be low.
  task automatic send(input logic [W-1:0] d, input logic last);
    check("in_ready_pre", in_ready, 1'b1);
    check("arr_valid_pre", arr_valid, 1'b0);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    if (m_cnt < N) begin
      m_frame[m_cnt] = d;
      m_cnt++;
    end
    if (last) begin
      q_frame.push_back(m_frame);
      q_cnt.push_back(m_cnt);
      model_clear();
      // The array must be offered on the edge right after in_last is accepted.
      check("arr_valid_latency", arr_valid, 1'b1);
    end
  endtask

  task automatic collect();
    int     waited;
    frame_t ef;
    int     ec;
    waited = 0;
    while (!arr_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("collect_valid", arr_valid, 1'b1);
    if (q_frame.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow observed=empty expected=frame");
    end else begin
      ef = q_frame.pop_front();
      ec = q_cnt.pop_front();
      check("arr_data", snap(), ef);
      check("arr_count", arr_count, ec);
      check("in_ready_hold", in_ready, 1'b0);
      check("overflow_err", overflow_err, exp_ovf);
    end
  endtask

  task automatic handoff();
    arr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arr_ready = 1'b0;
    check("in_ready_after_handoff", in_ready, 1'b1);
    check("arr_valid_after_handoff", arr_valid, 1'b0);
    check("arr_count_after_handoff", arr_count, 0);
    check("arr_data_after_handoff", snap(), pad_frame());
    check("overflow_sticky", overflow_err, exp_ovf);
  endtask

  initial begin
    frame_t held;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_data   = $urandom;
    arr_ready = 1'b0;
    exp_ovf   = 1'b0;
    model_clear();

    // T1: reset is held for 3 cycles with in_valid asserted.
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_arr_valid", arr_valid, 1'b0);
    check("rst_arr_count", arr_count, 0);
    check("rst_arr_data", snap(), pad_frame());
    check("rst_overflow", overflow_err, 1'b0);
    @(negedge clk);
    check("rst_in_ready_2", in_ready, 1'b1);

    // T2: short frame. An arr_ready pulse while arr_valid=0 must have no effect.
    send(32'd5, 1'b0);
    arr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arr_ready = 1'b0;
    check("stray_ready_count", arr_count, 1);
    check("stray_ready_valid", arr_valid, 1'b0);
    send(32'd3, 1'b0);
    send(32'd9, 1'b1);
    collect();
    handoff();

    // T3: full frame, with in_last in slot N-1.
    for (int i = 0; i < N; i++) send(W'(N - 1 - i), (i == N - 1));
    collect();
    handoff();

    // T4: overflow. Elements 9 and 10 are dropped.
    for (int i = 1; i <= 10; i++) begin
      send(W'(i), (i == 10));
      if (i == 8) check("ovf_before_drop", overflow_err, 1'b0);
      if (i == 9) begin
`ifdef LOADER_OVERFLOW_ERR_EN
        exp_ovf = 1'b1;
`endif
        check("ovf_first_drop", overflow_err, exp_ovf);
      end
    end
    collect();
    handoff();

    // Single-element frame.
    send(32'd77, 1'b1);
    collect();
    handoff();

    // T5: backpressure. Input traffic while HOLD is active must be ignored.
    send(32'd11, 1'b0);
    send(32'd22, 1'b1);
    held     = snap();
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = $urandom;
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_arr_valid", arr_valid, 1'b1);
    check("bp_arr_data_stable", snap(), held);
    collect();
    handoff();

    // T6: reset in the middle of a frame discards the partial frame and the
    // overflow flag.
    for (int i = 1; i <= 4; i++) send(W'(i), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    exp_ovf = 1'b0;
    check("midrst_count", arr_count, 0);
    check("midrst_data", snap(), pad_frame());
    check("midrst_overflow", overflow_err, 1'b0);
    send(32'd4, 1'b0);
    send(32'd2, 1'b1);
    collect();
    handoff();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
